// File: rtl/noaa_sensor_feeder.sv
`default_nettype none
// ============================================================================
// Module   : noaa_sensor_feeder
// Purpose  : Sits between a host and a temperature-averaging block.
//            A sample FIFO feeds registered TN/MODE to the averager on each
//            SAMPLE strobe. A result FIFO (first-word fall-through) collects
//            AVG_SD values on each DONE strobe for the host to read.
//            Sticky UNDERRUN/OVERFLOW flags record starved strobes and
//            dropped results.
// Ports    : CLK, RESET (synchronous, active-high)
//            WR_EN, WR_DATA[12:0], WR_FULL     - host sample push side
//            SAMPLE, TN[11:0], MODE            - averager sample side
//            DONE, AVG_SD[11:0]                - averager result side
//            RD_EN, RD_DATA[11:0], RD_EMPTY    - host result pop side
//            UNDERRUN, OVERFLOW, CLR_FLAGS     - sticky status
//            SAMPLE_CNT[15:0], RESULT_CNT[15:0] (only with
//            NOAA_SENSOR_FEEDER_STATS_EN defined)
// Config   : `define NOAA_SENSOR_FEEDER_STATS_EN adds the statistic counters.
// Revision : 1.0 - initial release
// ============================================================================
module noaa_sensor_feeder #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR_EN,
    input  logic [12:0] WR_DATA,
    output logic        WR_FULL,
    input  logic        SAMPLE,
    output logic [11:0] TN,
    output logic        MODE,
    input  logic        DONE,
    input  logic [11:0] AVG_SD,
    input  logic        RD_EN,
    output logic [11:0] RD_DATA,
    output logic        RD_EMPTY,
    output logic        UNDERRUN,
    output logic        OVERFLOW,
`ifdef NOAA_SENSOR_FEEDER_STATS_EN
    output logic [15:0] SAMPLE_CNT,
    output logic [15:0] RESULT_CNT,
`endif
    input  logic        CLR_FLAGS
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] c_IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [OAW:0] c_OUT_FULL = (OAW+1)'(OUT_DEPTH);

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    logic [12:0]    r_smem [IN_DEPTH];
    logic [IAW-1:0] r_swptr;
    logic [IAW-1:0] r_srptr;
    logic [IAW:0]   r_scnt;
    logic           w_spop;
    logic           w_spush;
    logic           w_sempty;

    assign w_sempty = (r_scnt == '0);
    assign w_spop   = SAMPLE && !w_sempty;
    // A full buffer still accepts a write when the head leaves this cycle.
    assign w_spush  = WR_EN && ((r_scnt != c_IN_FULL) || w_spop);
    assign WR_FULL  = (r_scnt == c_IN_FULL);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_swptr <= '0;
            r_srptr <= '0;
            r_scnt  <= '0;
        end else begin
            if (w_spush) r_swptr <= r_swptr + IAW'(1);
            if (w_spop)  r_srptr <= r_srptr + IAW'(1);
            case ({w_spush, w_spop})
                2'b10:   r_scnt <= r_scnt + (IAW+1)'(1);
                2'b01:   r_scnt <= r_scnt - (IAW+1)'(1);
                default: r_scnt <= r_scnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (!RESET && w_spush) r_smem[r_swptr] <= WR_DATA;
    end

    logic [11:0] r_tn;
    logic        r_mode;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tn   <= '0;
            r_mode <= 1'b0;
        end else if (w_spop) begin
            r_tn   <= r_smem[r_srptr][11:0];
            r_mode <= r_smem[r_srptr][12];
        end
    end

    assign TN   = r_tn;
    assign MODE = r_mode;

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    logic [11:0]    r_rmem [OUT_DEPTH];
    logic [OAW-1:0] r_rwptr;
    logic [OAW-1:0] r_rrptr;
    logic [OAW:0]   r_rcnt;
    logic           w_rpop;
    logic           w_rpush;
    logic           w_rempty;

    assign w_rempty = (r_rcnt == '0);
    assign w_rpop   = RD_EN && !w_rempty;
    assign w_rpush  = DONE && ((r_rcnt != c_OUT_FULL) || w_rpop);
    assign RD_EMPTY = w_rempty;
    assign RD_DATA  = w_rempty ? 12'h000 : r_rmem[r_rrptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rwptr <= '0;
            r_rrptr <= '0;
            r_rcnt  <= '0;
        end else begin
            if (w_rpush) r_rwptr <= r_rwptr + OAW'(1);
            if (w_rpop)  r_rrptr <= r_rrptr + OAW'(1);
            case ({w_rpush, w_rpop})
                2'b10:   r_rcnt <= r_rcnt + (OAW+1)'(1);
                2'b01:   r_rcnt <= r_rcnt - (OAW+1)'(1);
                default: r_rcnt <= r_rcnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && w_rpush) r_rmem[r_rwptr] <= AVG_SD;
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle beats CLR_FLAGS.
    // ------------------------------------------------------------------
    logic r_underrun;
    logic r_overflow;
    logic w_und_set;
    logic w_ovf_set;

    assign w_und_set = SAMPLE && w_sempty;
    assign w_ovf_set = DONE && !w_rpush;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_und_set)      r_underrun <= 1'b1;
            else if (CLR_FLAGS) r_underrun <= 1'b0;
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (CLR_FLAGS) r_overflow <= 1'b0;
        end
    end

    assign UNDERRUN = r_underrun;
    assign OVERFLOW = r_overflow;

`ifdef NOAA_SENSOR_FEEDER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: free-running 16-bit counters that wrap naturally.
    // ------------------------------------------------------------------
    logic [15:0] r_sample_cnt;
    logic [15:0] r_result_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sample_cnt <= '0;
            r_result_cnt <= '0;
        end else begin
            if (w_spop)  r_sample_cnt <= r_sample_cnt + 16'd1;
            if (w_rpush) r_result_cnt <= r_result_cnt + 16'd1;
        end
    end

    assign SAMPLE_CNT = r_sample_cnt;
    assign RESULT_CNT = r_result_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noaa_sensor_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_noaa_sensor_feeder
// Purpose  : Self-checking bench for noaa_sensor_feeder (IN_DEPTH=16,
//            OUT_DEPTH=8). Directed scenarios followed by random traffic,
//            all compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noaa_sensor_feeder;

    localparam int IND  = 16;
    localparam int OUTD = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        WR_EN = 1'b0;
    logic [12:0] WR_DATA = '0;
    logic        WR_FULL;
    logic        SAMPLE = 1'b0;
    logic [11:0] TN;
    logic        MODE;
    logic        DONE = 1'b0;
    logic [11:0] AVG_SD = '0;
    logic        RD_EN = 1'b0;
    logic [11:0] RD_DATA;
    logic        RD_EMPTY;
    logic        UNDERRUN;
    logic        OVERFLOW;
    logic        CLR_FLAGS = 1'b0;
`ifdef NOAA_SENSOR_FEEDER_STATS_EN
    logic [15:0] SAMPLE_CNT;
    logic [15:0] RESULT_CNT;
`endif

    noaa_sensor_feeder #(.IN_DEPTH(IND), .OUT_DEPTH(OUTD)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .WR_FULL   (WR_FULL),
        .SAMPLE    (SAMPLE),
        .TN        (TN),
        .MODE      (MODE),
        .DONE      (DONE),
        .AVG_SD    (AVG_SD),
        .RD_EN     (RD_EN),
        .RD_DATA   (RD_DATA),
        .RD_EMPTY  (RD_EMPTY),
        .UNDERRUN  (UNDERRUN),
        .OVERFLOW  (OVERFLOW),
`ifdef NOAA_SENSOR_FEEDER_STATS_EN
        .SAMPLE_CNT(SAMPLE_CNT),
        .RESULT_CNT(RESULT_CNT),
`endif
        .CLR_FLAGS (CLR_FLAGS)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [12:0] m_sq[$];
    logic [11:0] m_rq[$];
    logic [11:0] m_tn  = '0;
    logic        m_mode = 1'b0;
    logic        m_und = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_scnt = '0;
    logic [15:0] m_rcnt = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit s_empty, s_full, r_empty, r_full, spop, spush, rpop, rpush;
        logic [12:0] head;
        if (RESET) begin
            m_sq.delete(); m_rq.delete();
            m_tn = '0; m_mode = 1'b0; m_und = 1'b0; m_ovf = 1'b0;
            m_scnt = '0; m_rcnt = '0;
            return;
        end
        s_empty = (m_sq.size() == 0);
        s_full  = (m_sq.size() == IND);
        r_empty = (m_rq.size() == 0);
        r_full  = (m_rq.size() == OUTD);
        spop  = SAMPLE && !s_empty;
        spush = WR_EN && (!s_full || spop);
        rpop  = RD_EN && !r_empty;
        rpush = DONE && (!r_full || rpop);
        if (spop) begin
            head = m_sq.pop_front();
            m_tn = head[11:0]; m_mode = head[12]; m_scnt++;
        end
        if (spush) m_sq.push_back(WR_DATA);
        if (rpop)  void'(m_rq.pop_front());
        if (rpush) begin m_rq.push_back(AVG_SD); m_rcnt++; end
        if (SAMPLE && s_empty) m_und = 1'b1; else if (CLR_FLAGS) m_und = 1'b0;
        if (DONE && !rpush)    m_ovf = 1'b1; else if (CLR_FLAGS) m_ovf = 1'b0;
    endtask

    // One clock: model update, edge, then compare every output 1 ns later.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
        chk("tn",       16'(TN),       16'(m_tn));
        chk("mode",     16'(MODE),     16'(m_mode));
        chk("wr_full",  16'(WR_FULL),  16'(m_sq.size() == IND));
        chk("rd_empty", 16'(RD_EMPTY), 16'(m_rq.size() == 0));
        chk("rd_data",  16'(RD_DATA),  (m_rq.size() != 0) ? 16'(m_rq[0]) : 16'h0);
        chk("underrun", 16'(UNDERRUN), 16'(m_und));
        chk("overflow", 16'(OVERFLOW), 16'(m_ovf));
`ifdef NOAA_SENSOR_FEEDER_STATS_EN
        chk("sample_cnt", SAMPLE_CNT, m_scnt);
        chk("result_cnt", RESULT_CNT, m_rcnt);
`endif
    endtask

    task automatic idle_inputs();
        RESET = 0; WR_EN = 0; SAMPLE = 0; DONE = 0; RD_EN = 0; CLR_FLAGS = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); RESET = 1; cyc(); RESET = 0;
    endtask

    task automatic wr(input logic [12:0] d);
        WR_EN = 1; WR_DATA = d; cyc(); WR_EN = 0;
    endtask

    task automatic done_push(input logic [11:0] v);
        DONE = 1; AVG_SD = v; cyc(); DONE = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_wr_full",  16'(WR_FULL),  16'h0);
        chk("rst_rd_empty", 16'(RD_EMPTY), 16'h1);
        chk("rst_rd_data",  16'(RD_DATA),  16'h0);
        chk("rst_tn",       16'(TN),       16'h0);
        chk("rst_flags",    16'({UNDERRUN, OVERFLOW}), 16'h0);

        // Basic sample path with mode bit
        wr(13'h0100);
        wr(13'h1200);
        SAMPLE = 1; cyc();
        chk("s1_tn", 16'(TN), 16'h100); chk("s1_mode", 16'(MODE), 16'h0);
        cyc();
        chk("s2_tn", 16'(TN), 16'h200); chk("s2_mode", 16'(MODE), 16'h1);
        chk("s2_und", 16'(UNDERRUN), 16'h0);

        // Underrun, clear-vs-set priority
        cyc();
        chk("und_set", 16'(UNDERRUN), 16'h1);
        chk("und_hold_tn", 16'(TN), 16'h200);
        CLR_FLAGS = 1; cyc();
        chk("und_prio", 16'(UNDERRUN), 16'h1);
        SAMPLE = 0; cyc(); CLR_FLAGS = 0;
        chk("und_clr", 16'(UNDERRUN), 16'h0);

        // Same-cycle write into an empty buffer: no bypass
        WR_EN = 1; WR_DATA = 13'h0ABC; SAMPLE = 1; cyc(); idle_inputs();
        chk("nobypass_und", 16'(UNDERRUN), 16'h1);
        SAMPLE = 1; cyc(); SAMPLE = 0;
        chk("nobypass_tn", 16'(TN), 16'hABC);
        CLR_FLAGS = 1; cyc(); CLR_FLAGS = 0;

        // Fill past depth, then drain across pointer wrap
        for (int i = 1; i <= 17; i++) wr(13'(i));
        chk("full", 16'(WR_FULL), 16'h1);
        for (int i = 1; i <= 16; i++) begin
            SAMPLE = 1; cyc();
            chk("drain_tn", 16'(TN), 16'(i));
        end
        SAMPLE = 0;
        chk("drain_und", 16'(UNDERRUN), 16'h0);

        // Result overflow
        for (int i = 1; i <= 9; i++) done_push(12'(i));
        chk("ovf_set", 16'(OVERFLOW), 16'h1);
        chk("ovf_head", 16'(RD_DATA), 16'h1);
        CLR_FLAGS = 1; cyc(); CLR_FLAGS = 0;
        chk("ovf_clr", 16'(OVERFLOW), 16'h0);
        // Full + DONE + RD_EN: accepted, no overflow
        DONE = 1; AVG_SD = 12'h077; RD_EN = 1; cyc(); idle_inputs();
        chk("full_rw_ovf", 16'(OVERFLOW), 16'h0);
        for (int i = 2; i <= 8; i++) begin
            chk("rd_seq", 16'(RD_DATA), 16'(i));
            RD_EN = 1; cyc(); RD_EN = 0;
        end
        chk("rd_last", 16'(RD_DATA), 16'h077);
        RD_EN = 1; cyc(); cyc(); RD_EN = 0;   // second pop hits empty
        chk("rd_empty_ignored", 16'({RD_EMPTY, OVERFLOW}), 16'h2);

        // Mid-stream reset
        for (int i = 0; i < 5; i++) wr(13'(12'h300 + i));
        for (int i = 0; i < 3; i++) done_push(12'(12'h400 + i));
        SAMPLE = 1; cyc(); SAMPLE = 0;
        do_reset();
        chk("mrst_full",  16'(WR_FULL),  16'h0);
        chk("mrst_empty", 16'(RD_EMPTY), 16'h1);
        chk("mrst_tn",    16'(TN),       16'h0);
        SAMPLE = 1; cyc(); SAMPLE = 0;
        chk("mrst_und", 16'(UNDERRUN), 16'h1);

`ifdef NOAA_SENSOR_FEEDER_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) wr(13'(i + 5));
        SAMPLE = 1; cyc(); cyc(); cyc(); SAMPLE = 0;
        done_push(12'h011); done_push(12'h022);
        chk("stat_samples", SAMPLE_CNT, 16'd3);
        chk("stat_results", RESULT_CNT, 16'd2);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            RESET     = ($urandom_range(0, 199) == 0);
            WR_EN     = ($urandom_range(0, 99) < 55);
            WR_DATA   = 13'($urandom);
            SAMPLE    = ($urandom_range(0, 99) < 45);
            DONE      = ($urandom_range(0, 99) < 50);
            AVG_SD    = 12'($urandom);
            RD_EN     = ($urandom_range(0, 99) < 40);
            CLR_FLAGS = ($urandom_range(0, 19) == 0);
            cyc();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
